// File: rtl/trap_reservation_station.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trap_reservation_station: operand-collecting RS feeding the trap unit     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package trap_rs_pkg;
    typedef struct packed {
        logic [4:0] to_field;
        logic       imm_form;
    } trap_decode_t;
endpackage

module trap_reservation_station
    import trap_rs_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_OFFSET   = 0,
    parameter int RS_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic                   op1_valid,
    input  logic [31:0]            op1_value,
    input  logic [RS_ID_WIDTH-1:0] op1_rs_id,
    input  logic                   op2_valid,
    input  logic [31:0]            op2_value,
    input  logic [RS_ID_WIDTH-1:0] op2_rs_id,
    input  trap_decode_t           control,
    input  logic                   wb_valid,
    input  logic [RS_ID_WIDTH-1:0] wb_rs_id,
    input  logic [31:0]            wb_result,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    output logic [31:0]            issue_op1,
    output logic [31:0]            issue_op2,
    output trap_decode_t           issue_control
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    logic [RS_DEPTH-1:0]       busy_q, busy_d;
    logic [RS_DEPTH-1:0]       op1_rdy_q, op1_rdy_d;
    logic [RS_DEPTH-1:0]       op2_rdy_q, op2_rdy_d;
    logic [RS_DEPTH-1:0][31:0] op1_q, op1_d;
    logic [RS_DEPTH-1:0][31:0] op2_q, op2_d;
    trap_decode_t [RS_DEPTH-1:0] ctrl_q, ctrl_d;

    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;
    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic [RS_ID_WIDTH-1:0] sel_id;

    // Returns {rdy, data}; a not-yet-ready operand keeps its producer tag in the data field.
    function automatic logic [32:0] capture(
        input logic                   v,
        input logic [31:0]            val,
        input logic [RS_ID_WIDTH-1:0] tag,
        input logic                   wbv,
        input logic [RS_ID_WIDTH-1:0] wbtag,
        input logic [31:0]            wbres
    );
        if (v)
            return {1'b1, val};
        else if (wbv && (wbtag == tag))
            return {1'b1, wbres};
        else
            return {1'b0, 32'(tag)};
    endfunction

    always_comb begin : free_select
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!free_found && !busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign dispatch_ready = free_found;

    always_comb begin : issue_select
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_id    = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!sel_found && busy_q[i] && op1_rdy_q[i] && op2_rdy_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_id    = RS_ID_WIDTH'(RS_OFFSET + i);
            end
        end
    end

    always_comb begin : issue_outputs
        issue_valid   = sel_found;
        issue_rs_id   = '0;
        issue_op1     = '0;
        issue_op2     = '0;
        issue_control = '0;
        if (sel_found) begin
            issue_rs_id   = sel_id;
            issue_op1     = op1_q[sel_idx];
            issue_op2     = op2_q[sel_idx];
            issue_control = ctrl_q[sel_idx];
        end
    end

    always_comb begin : next_state
        busy_d    = busy_q;
        op1_rdy_d = op1_rdy_q;
        op2_rdy_d = op2_rdy_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        ctrl_d    = ctrl_q;

        for (int i = 0; i < RS_DEPTH; i++) begin
            if (busy_q[i] && wb_valid) begin
                if (!op1_rdy_q[i] && (op1_q[i][RS_ID_WIDTH-1:0] == wb_rs_id)) begin
                    op1_d[i]     = wb_result;
                    op1_rdy_d[i] = 1'b1;
                end
                if (!op2_rdy_q[i] && (op2_q[i][RS_ID_WIDTH-1:0] == wb_rs_id)) begin
                    op2_d[i]     = wb_result;
                    op2_rdy_d[i] = 1'b1;
                end
            end
        end

        if (sel_found && issue_ready) begin
            busy_d[sel_idx]    = 1'b0;
            op1_rdy_d[sel_idx] = 1'b0;
            op2_rdy_d[sel_idx] = 1'b0;
        end

        // free_idx comes from registered busy, so a slot freed this cycle is never reused here.
        if (dispatch_valid && free_found) begin
            busy_d[free_idx] = 1'b1;
            {op1_rdy_d[free_idx], op1_d[free_idx]} =
                capture(op1_valid, op1_value, op1_rs_id, wb_valid, wb_rs_id, wb_result);
            {op2_rdy_d[free_idx], op2_d[free_idx]} =
                capture(op2_valid, op2_value, op2_rs_id, wb_valid, wb_rs_id, wb_result);
            ctrl_d[free_idx] = control;
        end

        if (flush) begin
            busy_d    = '0;
            op1_rdy_d = '0;
            op2_rdy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q    <= '0;
            op1_rdy_q <= '0;
            op2_rdy_q <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            busy_q    <= busy_d;
            op1_rdy_q <= op1_rdy_d;
            op2_rdy_q <= op2_rdy_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            ctrl_q    <= ctrl_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trap_reservation_station.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_trap_reservation_station: vector table + scoreboard bench for the RS  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_trap_reservation_station;
    import trap_rs_pkg::*;

    localparam int IDW = 5;
    localparam int NV  = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           dispatch_valid;
    logic           dispatch_ready;
    logic           op1_valid;
    logic [31:0]    op1_value;
    logic [IDW-1:0] op1_rs_id;
    logic           op2_valid;
    logic [31:0]    op2_value;
    logic [IDW-1:0] op2_rs_id;
    trap_decode_t   control;
    logic           wb_valid;
    logic [IDW-1:0] wb_rs_id;
    logic [31:0]    wb_result;
    logic           issue_valid;
    logic           issue_ready;
    logic [IDW-1:0] issue_rs_id;
    logic [31:0]    issue_op1;
    logic [31:0]    issue_op2;
    trap_decode_t   issue_control;

    trap_reservation_station #(
        .RS_ID_WIDTH(IDW),
        .RS_OFFSET  (8),
        .RS_DEPTH   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .dispatch_valid(dispatch_valid),
        .dispatch_ready(dispatch_ready),
        .op1_valid     (op1_valid),
        .op1_value     (op1_value),
        .op1_rs_id     (op1_rs_id),
        .op2_valid     (op2_valid),
        .op2_value     (op2_value),
        .op2_rs_id     (op2_rs_id),
        .control       (control),
        .wb_valid      (wb_valid),
        .wb_rs_id      (wb_rs_id),
        .wb_result     (wb_result),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_rs_id   (issue_rs_id),
        .issue_op1     (issue_op1),
        .issue_op2     (issue_op2),
        .issue_control (issue_control)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           o1v;
        logic [31:0]    o1;
        logic [IDW-1:0] t1;
        logic           o2v;
        logic [31:0]    o2;
        logic [IDW-1:0] t2;
        logic           wbv;
        logic [IDW-1:0] wbt;
        logic [31:0]    wbr;
        trap_decode_t   ctl;
        logic [31:0]    e1;
        logic [31:0]    e2;
    } vec_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    op1;
        logic [31:0]    op2;
        trap_decode_t   ctl;
    } exp_t;

    vec_t vecs[NV];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic clear_inputs();
        flush          = 1'b0;
        dispatch_valid = 1'b0;
        op1_valid      = 1'b0;
        op1_value      = '0;
        op1_rs_id      = '0;
        op2_valid      = 1'b0;
        op2_value      = '0;
        op2_rs_id      = '0;
        control        = '0;
        wb_valid       = 1'b0;
        wb_rs_id       = '0;
        wb_result      = '0;
    endtask

    task automatic drive(input vec_t v);
        dispatch_valid = 1'b1;
        op1_valid      = v.o1v;
        op1_value      = v.o1;
        op1_rs_id      = v.t1;
        op2_valid      = v.o2v;
        op2_value      = v.o2;
        op2_rs_id      = v.t2;
        control        = v.ctl;
        wb_valid       = v.wbv;
        wb_rs_id       = v.wbt;
        wb_result      = v.wbr;
    endtask

    task automatic push_exp(input logic [IDW-1:0] id, input logic [31:0] a,
                            input logic [31:0] b, input trap_decode_t c);
        exp_t e;
        e.id  = id;
        e.op1 = a;
        e.op2 = b;
        e.ctl = c;
        sb.push_back(e);
    endtask

    // Compared at the handshake cycle, i.e. the data the trap unit actually samples.
    task automatic pop_check(input string name);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s_sb: got handshake, expected empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_valid"}, 32'(issue_valid), 32'd1);
            chk({name, "_id"}, 32'(issue_rs_id), 32'(e.id));
            chk({name, "_op1"}, issue_op1, e.op1);
            chk({name, "_op2"}, issue_op2, e.op2);
            chk({name, "_ctl"}, 32'(issue_control), 32'(e.ctl));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h5, 5'd0, 1'b1, 32'h3, 5'd0, 1'b0, 5'd0, 32'h0,
                    trap_decode_t'{5'b01000, 1'b0}, 32'h5, 32'h3};
        vecs[1] = '{1'b1, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0, 5'd7, 1'b1, 5'd7, 32'h1234,
                    trap_decode_t'{5'b00100, 1'b1}, 32'hDEADBEEF, 32'h1234};
        vecs[2] = '{1'b0, 32'h0, 5'd2, 1'b1, 32'h10, 5'd0, 1'b1, 5'd2, 32'hA5A5A5A5,
                    trap_decode_t'{5'b11111, 1'b1}, 32'hA5A5A5A5, 32'h10};
        vecs[3] = '{1'b0, 32'h0, 5'd9, 1'b0, 32'h0, 5'd9, 1'b1, 5'd9, 32'h77,
                    trap_decode_t'{5'b00011, 1'b0}, 32'h77, 32'h77};
        vecs[4] = '{1'b1, 32'h1, 5'd4, 1'b1, 32'h2, 5'd0, 1'b1, 5'd4, 32'h99,
                    trap_decode_t'{5'b10000, 1'b0}, 32'h1, 32'h2};

        clear_inputs();
        issue_ready = 1'b0;
        rst         = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        chk("rst_dready", 32'(dispatch_ready), 32'd1);
        chk("rst_ivalid", 32'(issue_valid), 32'd0);
        chk("rst_id", 32'(issue_rs_id), 32'd0);
        chk("rst_op1", issue_op1, 32'd0);
        chk("rst_op2", issue_op2, 32'd0);
        chk("rst_ctl", 32'(issue_control), 32'd0);

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k]);
            push_exp(5'd8, vecs[k].e1, vecs[k].e2, vecs[k].ctl);
            tick();
            clear_inputs();
            chk($sformatf("tbl%0d_latency", k), 32'(issue_valid), 32'd1);
            issue_ready = 1'b1;
            pop_check($sformatf("tbl%0d", k));
            tick();
            issue_ready = 1'b0;
            chk($sformatf("tbl%0d_freed", k), 32'(issue_valid), 32'd0);
        end

        // op1 waits on tag 3; an unrelated writeback must not wake it.
        dispatch_valid = 1'b1;
        op1_rs_id      = 5'd3;
        op2_valid      = 1'b1;
        op2_value      = 32'h10;
        control        = trap_decode_t'{5'b00100, 1'b0};
        push_exp(5'd8, 32'hFFFFFFFF, 32'h10, trap_decode_t'{5'b00100, 1'b0});
        tick();
        clear_inputs();
        chk("snoop_wait", 32'(issue_valid), 32'd0);
        wb_valid  = 1'b1;
        wb_rs_id  = 5'd5;
        wb_result = 32'h55;
        tick();
        chk("snoop_nomatch", 32'(issue_valid), 32'd0);
        wb_rs_id  = 5'd3;
        wb_result = 32'hFFFFFFFF;
        chk("snoop_same_cycle", 32'(issue_valid), 32'd0);
        tick();
        clear_inputs();
        issue_ready = 1'b1;
        pop_check("snoop");
        tick();
        issue_ready = 1'b0;
        chk("snoop_freed", 32'(issue_valid), 32'd0);

        // Both operands waiting on the same tag capture together.
        dispatch_valid = 1'b1;
        op1_rs_id      = 5'd6;
        op2_rs_id      = 5'd6;
        push_exp(5'd8, 32'hCAFE, 32'hCAFE, trap_decode_t'(6'd0));
        tick();
        clear_inputs();
        wb_valid  = 1'b1;
        wb_rs_id  = 5'd6;
        wb_result = 32'hCAFE;
        tick();
        clear_inputs();
        issue_ready = 1'b1;
        pop_check("snoop2");
        tick();
        issue_ready = 1'b0;

        // Fill all four entries with issue stalled.
        for (int k = 0; k < 4; k++) begin
            dispatch_valid = 1'b1;
            op1_valid      = 1'b1;
            op1_value      = 32'h100 + 32'(k);
            op2_valid      = 1'b1;
            op2_value      = 32'h200 + 32'(k);
            tick();
        end
        op1_value = 32'hBAD;
        op2_value = 32'hBAD;
        chk("full_dready", 32'(dispatch_ready), 32'd0);
        chk("full_sel_id", 32'(issue_rs_id), 32'd8);
        tick();
        clear_inputs();
        chk("full_ignored_op1", issue_op1, 32'h100);
        chk("full_ignored_id", 32'(issue_rs_id), 32'd8);
        chk("full_still", 32'(dispatch_ready), 32'd0);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("freed_dready", 32'(dispatch_ready), 32'd1);
        chk("freed_next_id", 32'(issue_rs_id), 32'd9);
        chk("freed_next_op1", issue_op1, 32'h101);
        dispatch_valid = 1'b1;
        op1_valid      = 1'b1;
        op1_value      = 32'h300;
        op2_valid      = 1'b1;
        op2_value      = 32'h301;
        tick();
        clear_inputs();
        chk("realloc_full", 32'(dispatch_ready), 32'd0);
        chk("realloc_id", 32'(issue_rs_id), 32'd8);
        chk("realloc_op1", issue_op1, 32'h300);

        // Dispatch while full, concurrent with issue: the freed slot is not reused this cycle.
        dispatch_valid = 1'b1;
        op1_valid      = 1'b1;
        op1_value      = 32'hBAD;
        op2_valid      = 1'b1;
        op2_value      = 32'hBAD;
        issue_ready    = 1'b1;
        chk("simul_dready", 32'(dispatch_ready), 32'd0);
        tick();
        clear_inputs();
        issue_ready = 1'b0;
        chk("simul_dready_next", 32'(dispatch_ready), 32'd1);
        chk("simul_id", 32'(issue_rs_id), 32'd9);
        chk("simul_op1", issue_op1, 32'h101);

        // Three entries busy: flush with dispatch and handshake in the same cycle.
        flush          = 1'b1;
        dispatch_valid = 1'b1;
        op1_valid      = 1'b1;
        op1_value      = 32'hF00;
        op2_valid      = 1'b1;
        op2_value      = 32'hF01;
        issue_ready    = 1'b1;
        chk("flush_visible", 32'(issue_valid), 32'd1);
        tick();
        clear_inputs();
        issue_ready = 1'b0;
        chk("flush_ivalid", 32'(issue_valid), 32'd0);
        chk("flush_dready", 32'(dispatch_ready), 32'd1);
        chk("flush_id", 32'(issue_rs_id), 32'd0);
        chk("flush_op1", issue_op1, 32'd0);
        tick();
        chk("flush_settled", 32'(issue_valid), 32'd0);

        // Reset wins over a concurrent dispatch.
        dispatch_valid = 1'b1;
        op1_valid      = 1'b1;
        op1_value      = 32'h42;
        op2_valid      = 1'b1;
        op2_value      = 32'h43;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_inputs();
        chk("rst2_ivalid", 32'(issue_valid), 32'd0);
        chk("rst2_op1", issue_op1, 32'd0);
        chk("rst2_dready", 32'(dispatch_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/trap_reservation_station.md
Name: trap_reservation_station

Overview:
- Reservation station directly upstream of the trap unit (tw/twi).
- Accepts dispatched trap instructions, holds them until both operands are available, snoops the GPR result bus for missing operands, and issues ready entries to the trap unit's input handshake.
- Each entry's RS ID travels with the instruction as its tag. The trap unit's rs_id_out/trap result is matched against it downstream.

Parameters:
- RS_ID_WIDTH, 5, width of RS ID/tag fields.
- RS_OFFSET, 0, RS ID of entry 0; entry i carries ID RS_OFFSET+i.
- RS_DEPTH, 4, number of entries (2..8). RS_OFFSET+RS_DEPTH-1 must fit in RS_ID_WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  discard all entries.
- dispatch_valid  in  1  dispatch request.
- dispatch_ready  out  1  at least one free entry.
- op1_valid  in  1  op1_value holds the operand; else wait on op1_rs_id.
- op1_value  in  32  operand 1 (rA).
- op1_rs_id  in  RS_ID_WIDTH  producer tag of operand 1.
- op2_valid / op2_value / op2_rs_id  in  1 / 32 / RS_ID_WIDTH  same for operand 2 (rB or SIMM, extended by decode).
- control  in  trap_decode_t  TO field etc.
- wb_valid  in  1  result bus valid.
- wb_rs_id  in  RS_ID_WIDTH  result bus producer tag.
- wb_result  in  32  result bus data.
- issue_valid  out  1  selected entry ready.
- issue_ready  in  1  trap unit input_ready.
- issue_rs_id  out  RS_ID_WIDTH  RS ID of issued entry.
- issue_op1, issue_op2  out  32  operands.
- issue_control  out  trap_decode_t  stored control.

Behaviour:
- Entry state: busy, op1_rdy, op2_rdy, op1/op2 value-or-tag, control.
- Reset (rst=0 at edge): all busy/rdy cleared, values/tags/control zeroed.
  - Outputs after reset: dispatch_ready=1, issue_valid=0, issue_rs_id=0, issue_op1=issue_op2=0, issue_control='0.
  - Reset has priority over flush, dispatch, snoop and issue.
- dispatch_ready = OR of ~busy, computed from registered state only. An entry freed by issue in cycle N is dispatchable in N+1, not N.
- Dispatch (dispatch_valid & dispatch_ready): allocates the lowest-index free entry at the edge.
  - opX_valid=1: stores opX_value, rdy=1.
  - opX_valid=0 and wb_valid with wb_rs_id==opX_rs_id in the same cycle: stores wb_result, rdy=1 (same-cycle bypass).
  - Otherwise: stores tag, rdy=0.
- Snoop: every busy entry with rdy=0 on operand X and tag==wb_rs_id while wb_valid=1 captures wb_result and sets rdy at the edge.
  - Both operands may capture in the same cycle.
  - The entry becomes issue-eligible the following cycle.
- Issue selection: combinational; lowest-index entry with busy & op1_rdy & op2_rdy.
  - issue_valid=1 iff such an entry exists.
  - issue_rs_id/op1/op2/control are driven from that entry.
  - When no entry is eligible, data outputs hold zero.
- Issue handshake: issue_valid & issue_ready frees the selected entry at the edge.
  - No combinational path from issue_ready to dispatch_ready.
  - issue_valid never depends on issue_ready.
  - Selection may change while issue_valid is stalled only if a lower-index entry becomes ready (acceptable: the trap unit samples only on handshake).
- Latency: dispatch with both operands valid at edge N → issue_valid=1 in cycle N+1 (one cycle minimum).
- Simultaneous dispatch + issue: both occur; the dispatched entry cannot reuse the entry freed in the same cycle.
- Full: dispatch_ready=0; a dispatch_valid asserted while full is ignored and must not corrupt state.
- Flush=1 at edge: all busy cleared; concurrent dispatch and issue handshake are discarded. issue_valid is still visible combinationally during the flush cycle; the consumer ignores it per pipeline flush rules.
- A wb_rs_id matching no waiting tag has no effect. A tag equal to the station's own IDs is legal (chained traps are not produced, but capture still works).

Test Plan:
- Reset: hold rst=0 three cycles, release → dispatch_ready=1, issue_valid=0, all issue data outputs 0.
- Dispatch op1=0x00000005, op2=0x00000003, both valid, TO=5'b01000, RS_OFFSET=8 → next cycle issue_valid=1, issue_rs_id=8, issue_op1=5, issue_op2=3; with issue_ready=1 → entry freed, issue_valid=0 next cycle.
- Dispatch op1 waiting on tag 3, op2=0x10 valid → issue_valid stays 0; wb_valid=1, wb_rs_id=3, wb_result=0xFFFFFFFF → issue_valid=1 one cycle later with issue_op1=0xFFFFFFFF.
- Same-cycle bypass: dispatch op2 waiting on tag 7 while wb_valid=1, wb_rs_id=7, wb_result=0x1234 → issue_op2=0x1234 next cycle.
- Fill 4 entries with issue_ready=0 → dispatch_ready=0; 5th dispatch ignored; one issue handshake → dispatch_ready=1 next cycle, lowest freed index reallocated.
- 3 busy entries, assert flush together with dispatch_valid and issue_ready → next cycle all entries free, issue_valid=0, dispatch_ready=1.
